// File: rtl/aes_ark_keysched_pkg.sv
// aes_ark_keysched_pkg: shared AES constants and helper functions.
//   AES_NR       - number of AES-128 rounds (10)
//   aes_rcon()   - round constant for key-expansion step r (0..9)
//   aes_sbox()   - forward S-box lookup, also used by the SubBytes stage
package aes_ark_keysched_pkg;

  localparam int AES_NR = 10;

  // Forward S-box. Row 0 of the standard table sits in the MSBs, so entry
  // b lives at bits [2047-8b -: 8].
  // NOTE: this is a constant table (a ROM), not state; it has no reset and
  // needs none.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX_TABLE[idx -: 8];
  endfunction

  // Round constant used when stepping from round key r to r+1.
  function automatic logic [7:0] aes_rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_ark_keysched_if.sv
// aes_ark_keysched_if: key-load, input-stream and output-stream signals of
// the AddRoundKey stage.
//   slave  - the stage itself (consumes key/state, produces state_out)
//   master - the environment driving it (upstream source + downstream sink)
interface aes_ark_keysched_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [3:0]   out_round;
  logic         out_last;

  modport slave (
    input  key_load, key_in, in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out, out_round, out_last
  );

  modport master (
    output key_load, key_in, in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out, out_round, out_last
  );
endinterface

// File: rtl/aes_ark_keysched_key_step.sv
// aes_ark_keysched_key_step: combinational AES-128 key-expansion step.
//   rkey     - current round key, word w0 at [127:96]
//   round    - index of rkey (0..9), selects the round constant
//   next_key - round key for round+1
module aes_ark_keysched_key_step
  import aes_ark_keysched_pkg::*;
(
  input  logic [127:0] rkey,
  input  logic [3:0]   round,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rkey;

  // RotWord: cyclic left rotation by one byte.
  assign rot = {w3[23:0], w3[31:24]};

  // SubWord: four parallel S-box lookups.
  for (genvar g = 0; g < 4; g++) begin : g_sub
    assign sub[8*g +: 8] = aes_sbox(rot[8*g +: 8]);
  end

  assign t = sub ^ {aes_rcon(round), 24'h000000};

  // NOTE: blocking assignments are correct in combinational logic; each new
  // word depends on the one computed just before it in the same evaluation.
  always_comb begin
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
  end

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_ark_keysched.sv
// aes_ark_keysched: registered AddRoundKey with on-the-fly AES-128 key
// expansion. Each accepted 128-bit state is XORed with the current round key
// and registered; the key schedule then advances one round, wrapping back to
// the cipher key after round NR.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - key load, state_in stream (valid/ready), state_out stream
//         (valid/ready) with out_round / out_last tags
// NR must stay at 10: only AES-128 key expansion is implemented.
module aes_ark_keysched
  import aes_ark_keysched_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_ark_keysched_if.slave    bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  logic [127:0] cipher_key;
  logic [127:0] rkey;
  logic [127:0] next_key;
  logic [3:0]   round;
  logic         key_ok;

  logic [127:0] state_q;
  logic [3:0]   round_q;
  logic         last_q;
  logic         valid_q;

  logic         in_ready;
  logic         accept;

  aes_ark_keysched_key_step u_key_step (
    .rkey     (rkey),
    .round    (round),
    .next_key (next_key)
  );

  // key_load takes priority over a beat presented in the same cycle, and the
  // output register may be refilled while it drains.
  // NOTE: every signal here is driven on all paths by a continuous
  // assignment, so no storage (latch) can be inferred.
  assign in_ready = key_ok && !bus.key_load && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cipher_key <= '0;
      rkey       <= '0;
      round      <= '0;
      key_ok     <= 1'b0;
      state_q    <= '0;
      round_q    <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else if (bus.key_load) begin
      // Load a new key and abort any block in flight.
      cipher_key <= bus.key_in;
      rkey       <= bus.key_in;
      round      <= '0;
      key_ok     <= 1'b1;
      valid_q    <= 1'b0;
    end else if (accept) begin
      state_q <= bus.state_in ^ rkey;
      round_q <= round;
      last_q  <= (round == LAST_ROUND);
      valid_q <= 1'b1;
      if (round == LAST_ROUND) begin
        // Block finished: rewind the schedule for the next block.
        rkey  <= cipher_key;
        round <= '0;
      end else begin
        rkey  <= next_key;
        round <= round + 4'd1;
      end
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.state_out = state_q;
  assign bus.out_round = round_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_aes_ark_keysched.sv
// tb_aes_ark_keysched: directed self-checking bench for aes_ark_keysched
// using the FIPS-197 Appendix A.1 / B key and plaintext.
module tb_aes_ark_keysched;

  logic clk;
  logic rst;

  aes_ark_keysched_if bus ();

  aes_ark_keysched #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] WHITE = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] KEY2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  // Expanded round keys of KEY (FIPS-197 Appendix A.1).
  logic [127:0] rk [11];
  initial begin
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after a blocking input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.key_load  = 1'b0;
    bus.key_in    = '0;
    bus.in_valid  = 1'b0;
    bus.state_in  = '0;
    bus.out_ready = 1'b1;

    // ---- reset state ----
    #12;
    check("rst out_valid", 128'(bus.out_valid), 128'(0));
    check("rst state_out", bus.state_out, '0);
    check("rst out_round", 128'(bus.out_round), 128'(0));
    check("rst in_ready", 128'(bus.in_ready), 128'(0));
    tick();
    rst = 1'b0;

    // ---- no key loaded yet: beat must be refused ----
    bus.in_valid = 1'b1;
    bus.state_in = PT;
    settle();
    check("nokey in_ready", 128'(bus.in_ready), 128'(0));
    tick();
    check("nokey out_valid", 128'(bus.out_valid), 128'(0));

    // ---- conflict: key_load with in_valid ----
    bus.key_load = 1'b1;
    bus.key_in   = KEY;
    settle();
    check("conflict in_ready", 128'(bus.in_ready), 128'(0));
    tick();
    bus.key_load = 1'b0;
    check("conflict out_valid", 128'(bus.out_valid), 128'(0));

    // ---- whitening: plaintext as round 0 ----
    settle();
    check("white in_ready", 128'(bus.in_ready), 128'(1));
    tick();
    check("white state_out", bus.state_out, WHITE);
    check("white out_round", 128'(bus.out_round), 128'(0));
    check("white out_valid", 128'(bus.out_valid), 128'(1));
    check("white out_last", 128'(bus.out_last), 128'(0));
    bus.in_valid = 1'b0;
    tick();
    check("drain out_valid", 128'(bus.out_valid), 128'(0));

    // ---- full key schedule with zero states, back to back ----
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    bus.state_in = '0;
    bus.in_valid = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      settle();
      check($sformatf("sched in_ready r%0d", i), 128'(bus.in_ready), 128'(1));
      tick();
      check($sformatf("sched state r%0d", i), bus.state_out, rk[i]);
      check($sformatf("sched round r%0d", i), 128'(bus.out_round), 128'(i));
      check($sformatf("sched last r%0d", i), 128'(bus.out_last),
            128'(i == 10));
    end
    tick();
    check("wrap state_out", bus.state_out, KEY);
    check("wrap out_round", 128'(bus.out_round), 128'(0));
    check("wrap out_last", 128'(bus.out_last), 128'(0));
    bus.in_valid = 1'b0;
    tick();

    // ---- backpressure after round 2 ----
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    bus.in_valid = 1'b1;
    repeat (3) tick();
    check("bp pre round", 128'(bus.out_round), 128'(2));
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("bp in_ready c%0d", c), 128'(bus.in_ready), 128'(0));
      tick();
      check($sformatf("bp state c%0d", c), bus.state_out, rk[2]);
      check($sformatf("bp round c%0d", c), 128'(bus.out_round), 128'(2));
      check($sformatf("bp valid c%0d", c), 128'(bus.out_valid), 128'(1));
    end
    bus.out_ready = 1'b1;
    settle();
    check("bp release in_ready", 128'(bus.in_ready), 128'(1));
    tick();
    check("bp release round", 128'(bus.out_round), 128'(3));
    check("bp release state", bus.state_out, rk[3]);

    // ---- abort with a new key at round 5 ----
    tick();
    tick();
    check("abort pre round", 128'(bus.out_round), 128'(5));
    bus.in_valid = 1'b0;
    bus.key_load = 1'b1;
    bus.key_in   = KEY2;
    tick();
    bus.key_load = 1'b0;
    check("abort out_valid", 128'(bus.out_valid), 128'(0));
    bus.in_valid = 1'b1;
    tick();
    check("abort new round", 128'(bus.out_round), 128'(0));
    check("abort new state", bus.state_out, KEY2);
    tick();
    check("key2 r1 state", bus.state_out, KEY2_R1);
    check("key2 r1 valid", 128'(bus.out_valid), 128'(1));

    // ---- asynchronous reset mid-block ----
    #2;
    rst = 1'b1;
    #1;
    check("arst out_valid", 128'(bus.out_valid), 128'(0));
    check("arst state_out", bus.state_out, '0);
    check("arst out_round", 128'(bus.out_round), 128'(0));
    check("arst out_last", 128'(bus.out_last), 128'(0));
    check("arst in_ready", 128'(bus.in_ready), 128'(0));
    tick();
    rst = 1'b0;
    settle();
    check("post rst in_ready", 128'(bus.in_ready), 128'(0));
    tick();
    check("post rst out_valid", 128'(bus.out_valid), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_ark_keysched.md
# aes_ark_keysched

Registered AddRoundKey stage with on-the-fly AES-128 key expansion. It sits directly downstream of `aes_mixcolumns` in the iterative encryption datapath. It consumes one 128-bit state per round and XORs it with the current round key. It registers the result, then advances the key schedule by one round, so no 176-byte expanded-key memory is needed.

## Interface
Parameters:
- `NR`, default 10: number of rounds. AES-128 only; no other value is supported.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `key_load`, input, 1: one-cycle pulse that loads `key_in` as the cipher key.
- `key_in`, input, 128: cipher key, byte 0 at [127:120].
- `in_valid`, input, 1: `state_in` is valid.
- `in_ready`, output, 1: the stage can accept `state_in` this cycle.
- `state_in`, input, 128: column-major state, same byte order as `aes_mixcolumns`.
- `out_valid`, output, 1: `state_out` is valid.
- `out_ready`, input, 1: the downstream stage accepts `state_out`.
- `state_out`, output, 128: `state_in` XOR the round key.
- `out_round`, output, 4: round index (0..NR) of the round key used for `state_out`.
- `out_last`, output, 1: high when `out_round == NR`, i.e. the ciphertext beat.

## Operation
Registers:
- `cipher_key` (128 bits).
- `rkey`, the current round key (128 bits).
- `round`, a 4-bit counter.
- `key_ok`, 1 bit.
- Output register holding `state_out`, `out_round`, `out_last` and `out_valid`.

Key load:
- `key_load` sets `cipher_key` and `rkey` to `key_in`, `round` to 0 and `key_ok` to 1.
- It also clears `out_valid`, aborting any block in flight.

Accept condition:
- A beat is accepted when `in_valid && in_ready`.
- `in_ready = key_ok && !key_load && (!out_valid || out_ready)`.

On each accepted beat:
- `state_out <= state_in ^ rkey`, `out_round <= round`, `out_last <= (round == NR)`, `out_valid <= 1`.
- If `round < NR`, `rkey` advances to the next round key and `round` increments.
- If `round == NR`, `rkey` reloads from `cipher_key` and `round` wraps to 0, ready for the next block.

Next-round-key step (FIPS-197):
- w0..w3 are the 32-bit words of `rkey`, w0 at [127:96].
- `t = SubWord(RotWord(w3)) ^ {RCON[round], 24'h0}`.
- New words: `w0' = w0 ^ t`, `w1' = w1 ^ w0'`, `w2' = w2 ^ w1'`, `w3' = w3 ^ w2'`.
- RCON for rounds 0..9: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.

Round usage:
- Round 0 is input whitening: upstream presents the plaintext.
- Rounds 1..NR-1 carry the `aes_mixcolumns` output.
- Round NR carries the ShiftRows output directly, bypassing MixColumns.

Other behaviour:
- When no beat is accepted and `out_ready` is high, `out_valid` clears.
- Before the first `key_load`, `in_ready` is 0 and nothing is accepted.

## Timing
Reset values:
- All of `state_out`, `out_round`, `out_last`, `out_valid`, `rkey`, `cipher_key`, `round` and `key_ok` are 0.
- `in_ready` is therefore 0 out of reset.

Throughput and latency:
- Latency is 1 cycle from accept to `out_valid`.
- Throughput is 1 beat/cycle when `out_ready` is held high.
- A full block takes NR+1 = 11 beats.

Backpressure:
- With `out_valid && !out_ready`, `in_ready` is 0.
- The output register, `rkey` and `round` hold their values.

Simultaneous events:
- Accept and drain in the same cycle: the output is replaced and `out_valid` stays 1.
- `key_load` together with `in_valid`: `key_load` wins and the beat is not accepted.

Reset and abort:
- Reset mid-block clears everything.
- `key_load` mid-block restarts at round 0 with the new key.

Combinational path:
- The key step (4 S-box lookups plus an XOR chain) sits between `rkey` and `rkey`.
- There is no combinational path from `state_in` to any output.

## Structure
Shared include `aes_pkg.vh` holds:
- The AES_NR constant (10).
- The RCON table as a function of the round index.
- The `aes_sbox` forward-table function, also used by the SubBytes stage.

One sub-module is natural:
- `aes_key_step`: combinational, taking (`rkey`, `round`) and returning the next key.
- It instantiates 4 S-box lookups.

## Test plan
- **Whitening:** load key `2b7e151628aed2a6abf7158809cf4f3c`, present `3243f6a8885a308d313198a2e0370734` as round 0.
  - Expect `state_out = 193de3bea0f4e22b9ac68d2ae9f84808` and `out_round = 0`.
- **Key schedule:** same key, feed 11 zero states back-to-back with `out_ready = 1`.
  - Expect round 1 out `a0fafe1788542cb123a339392a6c7605`.
  - Expect round 10 out `d014f9a8c9ee2589e13f0cc8b6630ca6` with `out_last = 1`.
  - Expect the next beat to be `out_round = 0` with the cipher key again.
- **Backpressure:** hold `out_ready = 0` for 3 cycles after round 2.
  - Expect `in_ready = 0`, with `state_out` and `out_round` stable.
  - Expect no round skipped after release.
- **Abort:** pulse `key_load` with a new key at round 5.
  - Expect `out_valid` to drop.
  - Expect the next accepted beat to be round 0 under the new key.
- **Reset:** before any `key_load`, drive `in_valid = 1`.
  - Expect `in_ready = 0` and `out_valid = 0`.
  - Assert `rst` mid-block and expect all outputs 0 immediately, without waiting for a clock edge.
- **Conflict:** assert `key_load` and `in_valid` in the same cycle.
  - Expect the beat not to be consumed and `round` to be 0 afterwards.
